// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Size encodings, FSM states, strobe constants.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    RDWAIT,
    RESP
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [1:0] align_off(
    input logic [1:0] size,
    input logic [1:0] off
  );
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Two-port request/response bus between requesters
// and the data-memory arbiter.
interface dm_arbiter_if;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][1:0]  req_size;
  logic [1:0]       req_signed;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering: store strobes/replication and
// load extraction with sign or zero extension.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_signed,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    st_strb = STRB_W;
    st_data = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_strb = STRB_B << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_strb = STRB_H << {st_off[1], 1'b0};
        st_data = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    b = ld_raw[{ld_off, 3'b000} +: 8];
    h = ld_raw[{ld_off[1], 4'b0000} +: 16];
    ld_data = ld_raw;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & b[7]}}, b};
      SZ_HALF: ld_data = {{16{ld_signed & h[15]}}, h};
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter/sequencer for the data memory.
// DM_ARB_ALIGN_CHECK_EN enables misalign/reserved-size errors.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int OFFSET_SIZE = 12,
  parameter int BIT_SIZE    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  dm_arbiter_if.slave            bus,
  output logic [OFFSET_SIZE-1:0] mem_addr,
  output logic [3:0]             mem_we,
  output logic                   mem_re,
  output logic [BIT_SIZE-1:0]    mem_wdata,
  input  logic [BIT_SIZE-1:0]    mem_rdata
);

  state_t      state;
  logic        rr_ptr;
  logic        gnt;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_sgn;
  logic [31:0] rdata;
  logic        err;

  logic        sel;
  logic        any;
  logic        c_we;
  logic [1:0]  c_size;
  logic        c_sgn;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [1:0]  n_size;
  logic [1:0]  n_off;
  logic        c_err;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  logic        st_go;
  logic        unused_hi;

  always_comb begin
    case (bus.req_valid)
      2'b11:   sel = rr_ptr;
      2'b10:   sel = 1'b1;
      default: sel = 1'b0;
    endcase
  end

  // Outputs stay quiet while reset is held, even with requests pending.
  assign any     = (state == IDLE) && !rst && |bus.req_valid;
  assign c_we    = bus.req_we[sel];
  assign c_size  = bus.req_size[sel];
  assign c_sgn   = bus.req_signed[sel];
  assign c_addr  = bus.req_addr[sel];
  assign c_wdata = bus.req_wdata[sel];

`ifdef DM_ARB_ALIGN_CHECK_EN
  assign n_size = c_size;
  assign n_off  = c_addr[1:0];
  assign c_err  = misaligned(c_size, c_addr[1:0]);
`else
  assign n_size = (c_size == SZ_RSVD) ? SZ_WORD : c_size;
  assign n_off  = align_off(n_size, c_addr[1:0]);
  assign c_err  = 1'b0;
`endif

  assign unused_hi = ^c_addr[31:OFFSET_SIZE+2];

  dm_lane_align u_lane (
    .st_size  (n_size),
    .st_off   (n_off),
    .st_wdata (c_wdata),
    .st_strb  (st_strb),
    .st_data  (st_data),
    .ld_size  (r_size),
    .ld_off   (r_off),
    .ld_signed(r_sgn),
    .ld_raw   (mem_rdata),
    .ld_data  (ld_data)
  );

  assign st_go     = any && c_we && !c_err;
  assign mem_we    = st_go ? st_strb : 4'b0000;
  assign mem_wdata = st_go ? st_data : '0;
  assign mem_re    = any && !c_we && !c_err;
  assign mem_addr  = any ? c_addr[OFFSET_SIZE+1:2] : '0;

  assign bus.req_ready = any ? (2'b01 << sel) : 2'b00;
  assign bus.rsp_valid = (state == RESP) ? (2'b01 << gnt) : 2'b00;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      gnt    <= 1'b0;
      r_size <= SZ_BYTE;
      r_off  <= 2'b00;
      r_sgn  <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          gnt    <= sel;
          r_size <= n_size;
          r_off  <= n_off;
          r_sgn  <= c_sgn;
          err    <= c_err;
          rdata  <= '0;
          if (bus.req_valid == 2'b11)
            rr_ptr <= ~sel;
          state  <= (c_we || c_err) ? RESP : RDWAIT;
        end
        RDWAIT: begin
          rdata <= ld_data;
          state <= RESP;
        end
        RESP: if (bus.rsp_ready[gnt])
          state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a
// behavioural one-cycle-latency memory.
module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic [11:0] mem_addr;
  logic [3:0]  mem_we;
  logic        mem_re;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [0:4095];

  int n_checks;
  int n_fail;

  dm_arbiter_if bus();

  dm_arbiter #(
    .OFFSET_SIZE(12),
    .BIT_SIZE   (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i])
        mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_re)
      mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(input int p,
                     input logic we,
                     input logic [1:0] sz,
                     input logic sg,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [3:0] xwe,
                     input logic xre,
                     input logic [31:0] xwd,
                     input int xlat,
                     input logic [31:0] xrd,
                     input logic xerr);
    int lat;
    @(negedge clk);
    bus.req_valid[p]  = 1'b1;
    bus.req_we[p]     = we;
    bus.req_size[p]   = sz;
    bus.req_signed[p] = sg;
    bus.req_addr[p]   = a;
    bus.req_wdata[p]  = wd;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(1 << p));
    chk("mem_we", 32'(mem_we), 32'(xwe));
    chk("mem_re", 32'(mem_re), 32'(xre));
    if (xre || xwe != 4'b0000)
      chk("mem_addr", 32'(mem_addr), (a >> 2) & 32'hFFF);
    if (xwe != 4'b0000)
      chk("mem_wdata", mem_wdata, xwd);
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.req_valid[p] = 1'b0;
      #1;
      if (bus.rsp_valid[p]) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(xlat));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << p));
    chk("rsp_rdata", bus.rsp_rdata, xrd);
    chk("rsp_err", 32'(bus.rsp_err), 32'(xerr));
    bus.rsp_ready[p] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[p] = 1'b0;
    #1;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] seen [4];
    int n;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem_rdata      = 32'd0;
    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_we     = 2'b00;
    bus.req_size   = '0;
    bus.req_signed = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 2'b00;

    #3;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // port, we, size, signed, addr, wdata, xwe, xre, xwdata, xlat, xrdata, xerr
    txn(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF,
        4'b1111, 0, 32'hDEADBEEF, 1, 32'h0, 0);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'hDEADBEEF, 0);
    txn(0, 1, 2'b00, 0, 32'h13, 32'h00000080,
        4'b1000, 0, 32'h80808080, 1, 32'h0, 0);
    txn(0, 0, 2'b00, 1, 32'h13, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'hFFFFFF80, 0);
    txn(0, 0, 2'b00, 0, 32'h13, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'h00000080, 0);
    txn(0, 1, 2'b10, 0, 32'h20, 32'hA5A5C3C3,
        4'b1111, 0, 32'hA5A5C3C3, 1, 32'h0, 0);
`ifdef DM_ARB_ALIGN_CHECK_EN
    txn(0, 0, 2'b01, 0, 32'h21, 32'h0,
        4'b0000, 0, 32'h0, 1, 32'h0, 1);
    txn(0, 1, 2'b11, 0, 32'h30, 32'h11223344,
        4'b0000, 0, 32'h0, 1, 32'h0, 1);
`else
    txn(0, 0, 2'b01, 0, 32'h21, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'h0000C3C3, 0);
    txn(0, 1, 2'b11, 0, 32'h30, 32'h11223344,
        4'b1111, 0, 32'h11223344, 1, 32'h0, 0);
`endif
    txn(0, 1, 2'b01, 0, 32'h22, 32'h00008001,
        4'b1100, 0, 32'h80018001, 1, 32'h0, 0);
    txn(0, 0, 2'b01, 1, 32'h22, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'hFFFF8001, 0);
    txn(0, 0, 2'b01, 0, 32'h22, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'h00008001, 0);
    txn(1, 0, 2'b10, 0, 32'h10, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'h80ADBEEF, 0);
    txn(1, 1, 2'b00, 0, 32'h4010, 32'h0000005A,
        4'b0001, 0, 32'h5A5A5A5A, 1, 32'h0, 0);
    txn(1, 0, 2'b10, 0, 32'h4010, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'h80ADBE5A, 0);

    // Round-robin with both ports requesting back to back.
    reset_pulse();
    for (int k = 0; k < 4; k++) seen[k] = 2'b00;
    n = 0;
    @(negedge clk);
    bus.req_we       = 2'b11;
    bus.req_size[0]  = 2'b10;
    bus.req_size[1]  = 2'b10;
    bus.req_addr[0]  = 32'h100;
    bus.req_addr[1]  = 32'h104;
    bus.req_wdata[0] = 32'h1;
    bus.req_wdata[1] = 32'h2;
    bus.rsp_ready    = 2'b11;
    bus.req_valid    = 2'b11;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        seen[n] = bus.req_ready;
        n++;
        if (n == 4) break;
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    bus.rsp_ready = 2'b00;
    for (int k = 0; k < 4; k++)
      chk("rr_grant", 32'(seen[k]), (k % 2 == 0) ? 32'd1 : 32'd2);

    // Stalled response, then reset in the middle of RESP.
    @(negedge clk);
    bus.req_valid[0]  = 1'b1;
    bus.req_we[0]     = 1'b0;
    bus.req_size[0]   = 2'b10;
    bus.req_signed[0] = 1'b0;
    bus.req_addr[0]   = 32'h10;
    @(negedge clk);
    bus.req_valid[0]  = 1'b0;
    @(negedge clk);
    bus.req_valid[1]  = 1'b1;
    bus.req_we[1]     = 1'b1;
    bus.req_size[1]   = 2'b10;
    bus.req_addr[1]   = 32'h200;
    bus.req_wdata[1]  = 32'hCAFEF00D;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, 32'h80ADBE5A);
      chk("hold_no_grant", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_req_ready", 32'(bus.req_ready), 32'd0);
    chk("mid_mem_we", 32'(mem_we), 32'd0);
    chk("mid_mem_re", 32'(mem_re), 32'd0);
    chk("mid_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_mem_wdata", mem_wdata, 32'd0);
    chk("mid_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("mid_rsp_err", 32'(bus.rsp_err), 32'd0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    txn(1, 0, 2'b10, 0, 32'h200, 32'h0,
        4'b0000, 1, 32'h0, 2, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data memory.
- Port 0 is the core load/store path; port 1 is the debug/DMA path.
- Arbitrates between the ports round-robin and converts byte addresses into word index plus 4-bit byte strobes.
- Sequences the one-cycle read latency of the memory and returns sign- or zero-extended load data through a valid/ready response handshake.

Parameters:
- OFFSET_SIZE, 12, log2 of memory depth in 32-bit words.
- BIT_SIZE, 32, data width; fixed at 32.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_valid  input  2  request valid, one bit per port
- req_ready  output  2  request accepted this cycle, per port
- req_we  input  2  1=store, 0=load, per port
- req_size  input  2x2  per port: 00 byte, 01 half, 10 word, 11 reserved
- req_signed  input  2  load extension per port: 1=sign, 0=zero
- req_addr  input  2x32  byte address per port
- req_wdata  input  2x32  store data, right-aligned, per port
- rsp_valid  output  2  response valid per port
- rsp_ready  input  2  response consumed per port
- rsp_rdata  output  32  load result, shared bus; qualified by rsp_valid
- rsp_err  output  1  misaligned or reserved-size error; qualified by rsp_valid
- mem_addr  output  OFFSET_SIZE  word index, equal to byte addr[OFFSET_SIZE+1:2]
- mem_we  output  4  byte write strobes; bit i writes bits 8i+7:8i
- mem_re  output  1  read strobe
- mem_wdata  output  32  lane-aligned store data
- mem_rdata  input  32  memory read data, valid the cycle after mem_re

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready, rsp_valid, mem_we, mem_re all 0.
  - rsp_rdata, rsp_err, mem_addr, mem_wdata all 0.
- State machine: IDLE -> (RDWAIT) -> RESP -> IDLE.
- IDLE:
  - Grant selection: if exactly one req_valid is set, that port is granted. If both are set, grant port rr_ptr, then set rr_ptr to the other port.
  - The granted port gets req_ready=1 for one cycle; request fields are registered.
  - Store: mem_we and mem_wdata are driven combinationally in the grant cycle. Next state is RESP with rsp_rdata=0.
  - Load: mem_re=1 and mem_addr are driven in the grant cycle. Next state is RDWAIT.
- RDWAIT (one cycle):
  - Capture mem_rdata.
  - Extract the addressed byte or half: byte lane addr[1:0], half lane addr[1].
  - Extend to 32 bits according to req_signed; word loads pass through unchanged.
  - Next state is RESP.
- RESP:
  - rsp_valid is set for the granted port only and held with stable data until rsp_ready.
  - On the cycle rsp_valid and rsp_ready are both 1, return to IDLE. No new grant is issued in that cycle.
- Store lanes:
  - Byte: strobe 0001<<addr[1:0]; data replicated as {4{wdata[7:0]}}.
  - Half: strobe 0011<<(2*addr[1]); data {2{wdata[15:0]}}.
  - Word: strobe 1111.
- Latency:
  - Store: response valid 1 cycle after grant.
  - Load: response valid 2 cycles after grant.
  - Best-case throughput is one transaction per 2 cycles for stores and per 3 cycles for loads.
- Errors:
  - Error conditions are half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - On error: no mem_we and no mem_re; go directly to RESP with rsp_err=1 and rsp_rdata=0.
- Addresses above the memory range wrap modulo 2^OFFSET_SIZE words.
- Reset mid-transaction aborts everything:
  - The pending response is lost and requesters must reissue.
  - A store whose strobes were driven before reset may or may not have committed.
- req_valid deasserted before req_ready is legal and causes no effect.

Optional Feature:
- Macro: DM_ARB_ALIGN_CHECK_EN.
- Defined: misalignment and reserved-size checks are active as described, and rsp_err is driven.
- Undefined:
  - rsp_err is tied to 0.
  - Low address bits are forced to alignment: half clears addr[0], word clears addr[1:0].
  - Size 11 is treated as word.

Decomposition:
- Package dm_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state enum IDLE/RDWAIT/RESP.
  - strobe constants.
- Sub-module dm_lane_align: combinational.
  - Store side: strobe and replicated wdata from size and addr[1:0].
  - Load side: extraction and sign/zero extension.
  - The arbiter FSM instantiates it once.

Test Plan:
- Port0 store word 0xDEADBEEF to addr 0x10, then load word from 0x10 -> mem_we=1111 at mem_addr=4; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store byte 0x80 to addr 0x13, load signed byte from 0x13 -> mem_we=1000, rsp_rdata=0xFFFFFF80. Unsigned load of the same byte -> 0x00000080.
- Store half 0x8001 to addr 0x22, load signed half -> mem_we=1100, rsp_rdata=0xFFFF8001. Unsigned -> 0x00008001.
- Both ports valid continuously for 4 transactions -> grants alternate 0,1,0,1 starting from port0 after reset.
- Load half from addr 0x21 with DM_ARB_ALIGN_CHECK_EN -> no mem_re, rsp_err=1, rsp_rdata=0. Without the macro, the load reads the half at 0x20.
- Hold rsp_ready=0 for 5 cycles, then assert rst mid-RESP -> rsp_valid stays stable until rst, then all outputs are 0 and state=IDLE.
